ram_sp_clr: RTL and testbench

Parametrised single-clock, simple-dual-port RAM (one write port, one read port) with per-byte write enables, write-first read-during-write forwarding, a selectable 1- or 2-cycle registered read latency with a valid strobe, and a hardware clear sequencer. The sequencer fills every word with a fixed value after reset and on request. It serves as the general data/scratch memory of the 16-bit computer, where a single system clock drives both ports.

---
 rtl/ram_sp_clr.sv | 160 ++++++++++++++++
 tb/tb_ram_sp_clr.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_clr.sv
// ram_sp_clr: simple-dual-port RAM with byte enables, write-first
// forwarding, 1/2-cycle registered read and a hardware clear sweep.
module ram_sp_clr #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DEPTH         = 1 << ADDRESS_WIDTH,
  parameter int BYTE_WIDTH    = 8,
  parameter int READ_LATENCY  = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic Write_Enable,
  input  logic [ADDRESS_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] Byte_Enable,
  input  logic [DATA_WIDTH-1:0] DATA_WRITE,
  input  logic Read_Enable,
  input  logic [ADDRESS_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0] DATA_READ,
  output logic Read_Valid,
  input  logic Clear_Start,
  output logic Busy
);

  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR =
    ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH:0] DEPTH_W =
    (ADDRESS_WIDTH+1)'(DEPTH);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDRESS_WIDTH-1:0] cnt;
  logic [ADDRESS_WIDTH-1:0] cnt_nxt;
  logic sweep_we;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic wr_in;
  logic rd_in;
  logic wr_go;
  logic rd_go;
  logic [DATA_WIDTH-1:0] rd_word;

  logic s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic out_go;
  logic [DATA_WIDTH-1:0] out_word;

  assign Busy  = (state == CLEAR);
  assign wr_in = ({1'b0, write_address} < DEPTH_W);
  assign rd_in = ({1'b0, read_address} < DEPTH_W);
  assign wr_go = Write_Enable && !Busy && wr_in;
  assign rd_go = Read_Enable && !Busy;

  // Sweep state and address counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: sweep every word, then serve users until a clear request
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sweep_we  = 1'b0;
    unique case (state)
      CLEAR: begin
        sweep_we = 1'b1;
        if (cnt == LAST_ADDR) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      READY: begin
        if (Clear_Start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Array write: the sweep owns the port while busy, else masked user write
  always_ff @(posedge clock) begin
    if (sweep_we) begin
      mem[cnt] <= CLEAR_VALUE;
    end else if (wr_go) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (Byte_Enable[i]) begin
          mem[write_address][i*BYTE_WIDTH +: BYTE_WIDTH] <=
            DATA_WRITE[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Read word with write-first merge of lanes written this cycle
  always_comb begin
    rd_word = CLEAR_VALUE;
    if (rd_in) begin
      rd_word = mem[read_address];
    end
    if (wr_go && (write_address == read_address)) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (Byte_Enable[i]) begin
          rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] =
            DATA_WRITE[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Optional first read stage; it drains even if a sweep starts
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_go;
      if (rd_go) begin
        s1_data <= rd_word;
      end
    end
  end

  assign out_go   = (READ_LATENCY == 2) ? s1_valid : rd_go;
  assign out_word = (READ_LATENCY == 2) ? s1_data : rd_word;

  // Output register: holds the last result until another read completes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      Read_Valid <= 1'b0;
      DATA_READ  <= '0;
    end else begin
      Read_Valid <= out_go;
      if (out_go) begin
        DATA_READ <= out_word;
      end
    end
  end

endmodule

// File: tb/tb_ram_sp_clr.sv
// tb_ram_sp_clr: scoreboard bench driving a latency-1 and a
// latency-2 instance with the same stimulus.
module tb_ram_sp_clr;

  localparam logic [15:0] CV = 16'hA5A5;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic Write_Enable = 1'b0;
  logic [3:0] write_address = '0;
  logic [1:0] Byte_Enable = '0;
  logic [15:0] DATA_WRITE = '0;
  logic Read_Enable = 1'b0;
  logic [3:0] read_address = '0;
  logic Clear_Start = 1'b0;

  logic [15:0] dr1, dr2;
  logic rv1, rv2, busy1, busy2;

  logic [15:0] model [16];
  logic [15:0] q1 [$];
  logic [15:0] q2 [$];
  logic [15:0] e1, e2;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ram_sp_clr #(
    .DATA_WIDTH(16), .ADDRESS_WIDTH(4), .DEPTH(16),
    .BYTE_WIDTH(8), .READ_LATENCY(1), .CLEAR_VALUE(CV)
  ) u1 (
    .clock(clock), .reset_n(reset_n),
    .Write_Enable(Write_Enable), .write_address(write_address),
    .Byte_Enable(Byte_Enable), .DATA_WRITE(DATA_WRITE),
    .Read_Enable(Read_Enable), .read_address(read_address),
    .DATA_READ(dr1), .Read_Valid(rv1),
    .Clear_Start(Clear_Start), .Busy(busy1)
  );

  ram_sp_clr #(
    .DATA_WIDTH(16), .ADDRESS_WIDTH(4), .DEPTH(16),
    .BYTE_WIDTH(8), .READ_LATENCY(2), .CLEAR_VALUE(CV)
  ) u2 (
    .clock(clock), .reset_n(reset_n),
    .Write_Enable(Write_Enable), .write_address(write_address),
    .Byte_Enable(Byte_Enable), .DATA_WRITE(DATA_WRITE),
    .Read_Enable(Read_Enable), .read_address(read_address),
    .DATA_READ(dr2), .Read_Valid(rv2),
    .Clear_Start(Clear_Start), .Busy(busy2)
  );

  always @(negedge clock) begin
    if (rv1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL lat1_unexpected_valid got %h want no valid", dr1);
      end else begin
        e1 = q1.pop_front();
        if (dr1 !== e1) begin
          errors++;
          $display("FAIL lat1_data got %h want %h", dr1, e1);
        end
      end
    end
    if (rv2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL lat2_unexpected_valid got %h want no valid", dr2);
      end else begin
        e2 = q2.pop_front();
        if (dr2 !== e2) begin
          errors++;
          $display("FAIL lat2_data got %h want %h", dr2, e2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic cyc();
    @(negedge clock);
    Write_Enable = 1'b0;
    Read_Enable  = 1'b0;
    Clear_Start  = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [3:0] wa,
                       input logic [1:0] be, input logic [15:0] wd,
                       input logic re, input logic [3:0] ra,
                       input logic [15:0] exp);
    @(negedge clock);
    Clear_Start   = 1'b0;
    Write_Enable  = we;
    write_address = wa;
    Byte_Enable   = be;
    DATA_WRITE    = wd;
    Read_Enable   = re;
    read_address  = ra;
    if (re) begin
      q1.push_back(exp);
      q2.push_back(exp);
    end
    if (we) begin
      for (int k = 0; k < 2; k++)
        if (be[k]) model[wa][k*8 +: 8] = wd[k*8 +: 8];
    end
  endtask

  task automatic drain(input string tag);
    repeat (4) cyc();
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d/%0d pending want 0/0",
               tag, q1.size(), q2.size());
      q1.delete();
      q2.delete();
    end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 16; i++)
      drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'(i), model[i]);
    drain(tag);
  endtask

  task automatic set_model_clear();
    for (int i = 0; i < 16; i++) model[i] = CV;
  endtask

  task automatic count_busy(input string tag, input int want);
    int n;
    n = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clock);
      n++;
      if (!busy1) break;
    end
    checks++;
    if (n != want || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_edges got %0d (busy2=%b) want %0d",
               tag, n, busy2, want);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1 || rv1 !== 1'b0 ||
        rv2 !== 1'b0 || dr1 !== 16'h0 || dr2 !== 16'h0) begin
      errors++;
      $display("FAIL reset_state got b%b%b v%b%b d%h/%h want b11 v00 d0",
               busy1, busy2, rv1, rv2, dr1, dr2);
    end
    @(negedge clock);
    reset_n = 1'b1;
    count_busy("post_reset", 16);
    set_model_clear();
    read_all("post_reset");
  endtask

  task automatic test_byte_lanes();
    drive(1'b1, 4'd3, 2'b11, 16'h1234, 1'b0, 4'd0, 16'h0);
    drive(1'b1, 4'd3, 2'b01, 16'hABCD, 1'b0, 4'd0, 16'h0);
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd3, 16'h12CD);
    drive(1'b1, 4'd3, 2'b00, 16'hFFFF, 1'b0, 4'd0, 16'h0);
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd3, 16'h12CD);
    drain("byte_lanes");
  endtask

  task automatic test_forward();
    drive(1'b1, 4'd5, 2'b11, 16'h0000, 1'b0, 4'd0, 16'h0);
    drive(1'b1, 4'd5, 2'b10, 16'hBEEF, 1'b1, 4'd5, 16'hBE00);
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd5, 16'hBE00);
    drain("forward");
  endtask

  task automatic test_clear();
    int n;
    for (int i = 0; i < 16; i++)
      drive(1'b1, 4'(i), 2'b11, 16'(i), 1'b0, 4'd0, 16'h0);
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd9, 16'd9);
    drain("clear_fill");
    @(negedge clock);
    Clear_Start   = 1'b1;
    Write_Enable  = 1'b1;
    write_address = 4'd0;
    Byte_Enable   = 2'b11;
    DATA_WRITE    = 16'h1111;
    n = 1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clock);
      Clear_Start = 1'b0;
      if (!busy1) begin
        Write_Enable = 1'b0;
        Read_Enable  = 1'b0;
        break;
      end
      n++;
      Clear_Start   = (n == 5);
      Write_Enable  = 1'b1;
      write_address = 4'(n);
      Byte_Enable   = 2'b11;
      DATA_WRITE    = 16'hFFFF;
      Read_Enable   = 1'b1;
      read_address  = 4'(n);
    end
    checks++;
    if (n != 17) begin
      errors++;
      $display("FAIL clear_busy_edges got %0d want 17", n);
    end
    checks++;
    if (dr1 !== 16'd9 || dr2 !== 16'd9) begin
      errors++;
      $display("FAIL clear_hold got %h/%h want 0009", dr1, dr2);
    end
    set_model_clear();
    read_all("after_clear");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++)
      drive(1'b1, 4'(i), 2'b11, 16'(i * 3 + 1), 1'b0, 4'd0, 16'h0);
    drive(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd2, 16'd7);
    drain("mid_fill");
    @(negedge clock);
    Clear_Start = 1'b1;
    repeat (8) cyc();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1 || dr1 !== 16'h0 ||
        dr2 !== 16'h0 || rv1 !== 1'b0 || rv2 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got b%b%b v%b%b d%h/%h want b11 v00 d0",
               busy1, busy2, rv1, rv2, dr1, dr2);
    end
    @(negedge clock);
    reset_n = 1'b1;
    count_busy("mid_reset", 16);
    set_model_clear();
    read_all("mid_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      drive(1'b1, 4'(i), 2'b11, 16'(8 * i), 1'b0, 4'd0, 16'h0);
    for (int j = 0; j <= 10; j++) begin
      @(negedge clock);
      Write_Enable = 1'b0;
      if (j >= 1) begin
        checks++;
        if (rv1 !== (j <= 8) || rv2 !== (j >= 2 && j <= 9)) begin
          errors++;
          $display("FAIL stream_valid cycle %0d got %b/%b want %b/%b",
                   j, rv1, rv2, (j <= 8), (j >= 2 && j <= 9));
        end
      end
      Read_Enable  = (j < 8);
      read_address = 4'(j);
      if (j < 8) begin
        q1.push_back(model[j]);
        q2.push_back(model[j]);
      end
    end
    Read_Enable = 1'b0;
    drain("stream");
    checks++;
    if (dr1 !== 16'd56 || dr2 !== 16'd56) begin
      errors++;
      $display("FAIL stream_hold got %h/%h want 0038", dr1, dr2);
    end
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_forward();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
